data_sram_resp: RTL and testbench
=================================

# data_sram_resp

Responder for the core's data SRAM port: it answers every `data_sram_we` / `data_sram_addr` / `data_sram_wdata` access from the core and returns `data_sram_rdata`. The block combines a word-addressed scratch RAM with a small memory-mapped register bank. The register bank holds the LED output, a synchronized switch input, and a free-running timer with compare interrupt. It sits outside `mycpu_top` in the SoC wrapper, in place of a bare data RAM.

## Interface
Parameters:
- `RAM_AW`, 10 — RAM depth is 2^RAM_AW words; RAM index is `addr[RAM_AW+1:2]`.
- `MMIO_HI`, 16'hbfaf — an access is MMIO when `addr[31:16] == MMIO_HI`; otherwise it is RAM.

Ports:
- `clk`  in  1  — the single clock.
- `resetn`  in  1  — reset, asynchronous and active-low.
- `data_sram_we`  in  1  — write strobe, full 32-bit word.
- `data_sram_addr`  in  32  — byte address; bits [1:0] are ignored.
- `data_sram_wdata`  in  32  — write data.
- `data_sram_rdata`  out  32  — registered read data.
- `switch_in`  in  8  — asynchronous board switches.
- `led_out`  out  16  — LED register.
- `timer_irq`  out  1  — timer interrupt, level output.

## Operation
- Every cycle is an access. There is no valid or ready handshake; the core qualifies its writes with `valid` before driving `data_sram_we`.
- RAM region:
  - Write at the edge when `we`=1.
  - Read every cycle.
  - Read-during-write to the same word returns the OLD data (read-first).
- MMIO register map, decoded on `addr[7:2]`:
  - 0x00 `SCRATCH`: read/write, 32 bits.
  - 0x04 `LED`: read/write, bits [15:0]; upper bits read 0; drives `led_out` directly.
  - 0x08 `SWITCH`: read-only; reads `{24'b0, sw_sync}`; writes are ignored.
  - 0x0C `TIMER`: read/write counter.
  - 0x10 `TCMP`: read/write compare value.
  - 0x14 `TCTRL`: bit0 `EN`, bit1 `IE`, bit2 `PEND`. Writing 1 to bit2 clears `PEND`; writing 0 to bit2 leaves it unchanged. Bits 0 and 1 are plain read/write.
  - Any other MMIO offset reads 0 and ignores writes.
- `sw_sync`: two-flop synchronizer on `switch_in`.
- Timer:
  - When `EN`=1 it increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
  - A CPU write to `TIMER` takes priority over the increment in the same cycle.
  - `PEND` sets in the cycle after the registered `TIMER` value equals `TCMP` while `EN`=1.
  - If a set and a write-1-clear of `PEND` occur in the same cycle, set wins.
- `timer_irq` = `PEND & IE`, taken from registered state.

## Timing
- Read latency is 1 cycle: the address presented before edge N appears on `data_sram_rdata` after edge N. The output is held until the next edge.
- A write is visible to a read issued in the following cycle, so back-to-back write then read of the same address returns the new data.
- `sw_sync` lags `switch_in` by 2 edges; `SWITCH` read data therefore reflects a switch change 3 edges after it.
- `timer_irq` rises 1 edge after the `TIMER == TCMP` match.
- Reset values (asynchronous assert, no dependence on `clk`):
  - Zero: `data_sram_rdata`, `SCRATCH`, `LED`/`led_out`, `TIMER`, `TCMP`, `TCTRL`, `sw_sync`, `timer_irq`.
  - RAM contents are not reset.
- Reset asserted mid-access: the write is dropped and the output is 0. The first access after `resetn` rises behaves normally at the first edge.

## Structure
- Package `data_sram_resp_pkg`:
  - register offset constants (`OFF_SCRATCH`, `OFF_LED`, `OFF_SWITCH`, `OFF_TIMER`, `OFF_TCMP`, `OFF_TCTRL`);
  - `TCTRL` bit indices;
  - the default `MMIO_HI`.
- Sub-module `sram_resp_ram`: single-port, read-first, registered-output word RAM with parameter `AW`, and no reset on the array.
- Top level: the region decode, a 1-cycle registered region select for the read mux, the register bank, timer, and synchronizer.

## Test plan
- Write 0x12345678 to RAM 0x1c000010, then read it in the next cycle → `rdata` = 0x12345678 one edge after the read address is presented; a same-cycle read of that word during the write returns the old value.
- Write 0xABCD to `LED` at 0xbfaf0004 → `led_out` = 0xABCD after the edge; reading it back returns 0x0000ABCD.
- Drive `switch_in` = 0x5A and read 0xbfaf0008 every cycle → 0 for the first 2 edges, then 0x0000005A.
- Set `TCMP` = 20 and `TCTRL` = 0x3 with `TIMER` = 0 → `timer_irq` rises 1 edge after `TIMER` reads 20. Writing `TCTRL` = 0x7 clears the interrupt; if the match and the clear coincide, the interrupt stays high.
- Write `TIMER` = 0xFFFFFFFE with `EN`=1 → the timer reads 0xFFFFFFFF, then 0x0; a write and an increment in the same cycle leave the written value.
- Deassert `resetn` mid-write → all outputs are 0 immediately (before the next edge); RAM words written before reset are still readable after release.

Source files
------------

// File: rtl/data_sram_resp_pkg.sv
// ============================================================================
// Module      : data_sram_resp_pkg
// Description : Register offsets, TCTRL bit indices and MMIO window default
//               for the data SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_sram_resp_pkg;

    localparam logic [15:0] MMIO_HI_DEFAULT = 16'hbfaf;

    // Word indices (addr[7:2]) of the byte offsets 0x00..0x14
    localparam logic [5:0] OFF_SCRATCH = 6'h00;
    localparam logic [5:0] OFF_LED     = 6'h01;
    localparam logic [5:0] OFF_SWITCH  = 6'h02;
    localparam logic [5:0] OFF_TIMER   = 6'h03;
    localparam logic [5:0] OFF_TCMP    = 6'h04;
    localparam logic [5:0] OFF_TCTRL   = 6'h05;

    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_IE   = 1;
    localparam int TCTRL_PEND = 2;

endpackage

`default_nettype wire

// File: rtl/data_sram_resp_if.sv
// ============================================================================
// Module      : data_sram_resp_if
// Description : Core data SRAM port: word write strobe, address, write data
//               and registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_sram_resp_if;

    logic        data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );

endinterface

`default_nettype wire

// File: rtl/data_sram_resp_ram.sv
// ============================================================================
// Module      : sram_resp_ram
// Description : Single-port read-first word RAM with a registered output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_resp_ram #(
    parameter int AW = 10
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_addr,
    input  wire logic [31:0]   i_wdata,
    output logic      [31:0]   o_rdata
);

    logic [31:0] r_mem [2**AW];

    // Writes are dropped while reset is held; the array itself is never cleared
    always_ff @(posedge clk) begin
        if (i_we && resetn) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_rdata <= '0;
        end else begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_sram_resp.sv
// ============================================================================
// Module      : data_sram_resp
// Description : Data SRAM responder: scratch RAM plus LED, switch and timer
//               registers mapped into the MMIO_HI window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int          RAM_AW  = 10,
    parameter logic [15:0] MMIO_HI = MMIO_HI_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    data_sram_resp_if.slave  bus,
    input  wire logic [7:0]  switch_in,
    output logic      [15:0] led_out,
    output logic             timer_irq
);

    logic        w_is_mmio;
    logic [5:0]  w_off;
    logic        w_wr_mmio;
    logic        w_ram_we;
    logic        w_timer_match;
    logic [31:0] w_mmio_rdata;
    logic [31:0] w_ram_rdata;

    logic        r_sel_mmio;
    logic [31:0] r_mmio_rdata;
    logic [31:0] r_scratch;
    logic [15:0] r_led;
    logic [31:0] r_timer;
    logic [31:0] r_tcmp;
    logic        r_en;
    logic        r_ie;
    logic        r_pend;
    logic [7:0]  r_sw_meta;
    logic [7:0]  r_sw_sync;

    assign w_is_mmio     = (bus.data_sram_addr[31:16] == MMIO_HI);
    assign w_off         = bus.data_sram_addr[7:2];
    assign w_wr_mmio     = bus.data_sram_we && w_is_mmio;
    assign w_ram_we      = bus.data_sram_we && !w_is_mmio;
    assign w_timer_match = r_en && (r_timer == r_tcmp);

    sram_resp_ram #(
        .AW (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .resetn  (resetn),
        .i_we    (w_ram_we),
        .i_addr  (bus.data_sram_addr[RAM_AW+1:2]),
        .i_wdata (bus.data_sram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_mmio_rdata = '0;
        case (w_off)
            OFF_SCRATCH: w_mmio_rdata = r_scratch;
            OFF_LED:     w_mmio_rdata = {16'h0000, r_led};
            OFF_SWITCH:  w_mmio_rdata = {24'h000000, r_sw_sync};
            OFF_TIMER:   w_mmio_rdata = r_timer;
            OFF_TCMP:    w_mmio_rdata = r_tcmp;
            OFF_TCTRL: begin
                w_mmio_rdata[TCTRL_EN]   = r_en;
                w_mmio_rdata[TCTRL_IE]   = r_ie;
                w_mmio_rdata[TCTRL_PEND] = r_pend;
            end
            default: w_mmio_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sel_mmio   <= 1'b0;
            r_mmio_rdata <= '0;
            r_scratch    <= '0;
            r_led        <= '0;
            r_timer      <= '0;
            r_tcmp       <= '0;
            r_en         <= 1'b0;
            r_ie         <= 1'b0;
            r_pend       <= 1'b0;
            r_sw_meta    <= '0;
            r_sw_sync    <= '0;
        end else begin
            r_sw_meta    <= switch_in;
            r_sw_sync    <= r_sw_meta;
            r_sel_mmio   <= w_is_mmio;
            r_mmio_rdata <= w_mmio_rdata;

            if (w_wr_mmio && (w_off == OFF_SCRATCH)) begin
                r_scratch <= bus.data_sram_wdata;
            end
            if (w_wr_mmio && (w_off == OFF_LED)) begin
                r_led <= bus.data_sram_wdata[15:0];
            end
            if (w_wr_mmio && (w_off == OFF_TCMP)) begin
                r_tcmp <= bus.data_sram_wdata;
            end

            // A CPU write to TIMER overrides the increment
            if (w_wr_mmio && (w_off == OFF_TIMER)) begin
                r_timer <= bus.data_sram_wdata;
            end else if (r_en) begin
                r_timer <= r_timer + 32'd1;
            end

            if (w_wr_mmio && (w_off == OFF_TCTRL)) begin
                r_en <= bus.data_sram_wdata[TCTRL_EN];
                r_ie <= bus.data_sram_wdata[TCTRL_IE];
            end

            // A compare match beats a simultaneous write-1-clear
            if (w_timer_match) begin
                r_pend <= 1'b1;
            end else if (w_wr_mmio && (w_off == OFF_TCTRL) && bus.data_sram_wdata[TCTRL_PEND]) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign bus.data_sram_rdata = r_sel_mmio ? r_mmio_rdata : w_ram_rdata;
    assign led_out             = r_led;
    assign timer_irq           = r_pend & r_ie;

endmodule

`default_nettype wire

// File: tb/tb_data_sram_resp.sv
// ============================================================================
// Module      : tb_data_sram_resp
// Description : Directed bench for data_sram_resp with a per-access reference
//               model compared on every falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_sram_resp;

    logic        clk;
    logic        resetn;
    logic [7:0]  switch_in;
    logic [15:0] led_out;
    logic        timer_irq;

    int total = 0;
    int bad   = 0;

    data_sram_resp_if bus ();

    data_sram_resp #(
        .RAM_AW  (10),
        .MMIO_HI (16'hbfaf)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .switch_in (switch_in),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one access per rising edge) ----------
    logic [31:0] m_ram [1024];
    bit          m_ramv [1024];
    logic [31:0] m_scratch = 0, m_timer = 0, m_tcmp = 0, m_rd = 0;
    logic [15:0] m_led = 0;
    logic [7:0]  m_sw1 = 0, m_sw2 = 0;
    logic        m_en = 0, m_ie = 0, m_pend = 0, m_rd_known = 1;
    logic [31:0] ma, md;
    logic        mwe, m_match;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_scratch = 0; m_timer = 0; m_tcmp = 0; m_led = 0;
            m_sw1 = 0; m_sw2 = 0; m_en = 0; m_ie = 0; m_pend = 0;
            m_rd = 0; m_rd_known = 1;
        end else begin
            ma  = bus.data_sram_addr;
            md  = bus.data_sram_wdata;
            mwe = bus.data_sram_we;
            m_match = m_en && (m_timer == m_tcmp);
            if (ma[31:16] == 16'hbfaf) begin
                m_rd_known = 1;
                case (ma[7:2])
                    6'd0:    m_rd = m_scratch;
                    6'd1:    m_rd = {16'h0, m_led};
                    6'd2:    m_rd = {24'h0, m_sw2};
                    6'd3:    m_rd = m_timer;
                    6'd4:    m_rd = m_tcmp;
                    6'd5:    m_rd = {29'h0, m_pend, m_ie, m_en};
                    default: m_rd = 0;
                endcase
            end else begin
                m_rd_known = m_ramv[ma[11:2]];
                m_rd       = m_ram[ma[11:2]];
            end
            if (m_en) m_timer = m_timer + 1;
            if (mwe && ma[31:16] == 16'hbfaf) begin
                case (ma[7:2])
                    6'd0: m_scratch = md;
                    6'd1: m_led     = md[15:0];
                    6'd3: m_timer   = md;
                    6'd4: m_tcmp    = md;
                    6'd5: begin
                        m_en = md[0];
                        m_ie = md[1];
                        if (md[2]) m_pend = 0;
                    end
                    default: ;
                endcase
            end else if (mwe) begin
                m_ram[ma[11:2]]  = md;
                m_ramv[ma[11:2]] = 1;
            end
            if (m_match) m_pend = 1;
            m_sw2 = m_sw1;
            m_sw1 = switch_in;
        end
    end

    always @(negedge clk) begin
        if (m_rd_known) check("model_rdata", bus.data_sram_rdata, m_rd);
        check("model_led", {16'h0, led_out}, {16'h0, m_led});
        check("model_irq", {31'h0, timer_irq}, {31'h0, m_pend & m_ie});
    end

    // ---------------- directed stimulus -------------------------------------
    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.data_sram_we    = we;
        bus.data_sram_addr  = a;
        bus.data_sram_wdata = d;
    endtask

    localparam logic [31:0] A_LED   = 32'hbfaf0004;
    localparam logic [31:0] A_SW    = 32'hbfaf0008;
    localparam logic [31:0] A_TIMER = 32'hbfaf000c;
    localparam logic [31:0] A_TCMP  = 32'hbfaf0010;
    localparam logic [31:0] A_TCTRL = 32'hbfaf0014;
    localparam logic [31:0] A_IDLE  = 32'h1c000000;

    initial begin
        resetn = 1'b0;
        switch_in = 8'h00;
        bus.data_sram_we = 1'b0;
        bus.data_sram_addr = A_IDLE;
        bus.data_sram_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", bus.data_sram_rdata, 32'h0);
        check("reset_led", {16'h0, led_out}, 32'h0);
        check("reset_irq", {31'h0, timer_irq}, 32'h0);
        resetn = 1'b1;

        // RAM write then read, and read-first on a colliding write
        drive(1'b1, 32'h1c000010, 32'h12345678);
        drive(1'b0, 32'h1c000010, 32'h0);
        drive(1'b0, A_IDLE, 32'h0);
        check("ram_wr_rd", bus.data_sram_rdata, 32'h12345678);
        drive(1'b1, 32'h1c000020, 32'h11111111);
        drive(1'b1, 32'h1c000020, 32'h22222222);
        drive(1'b0, 32'h1c000020, 32'h0);
        check("ram_read_first", bus.data_sram_rdata, 32'h11111111);
        drive(1'b0, A_IDLE, 32'h0);
        check("ram_new_data", bus.data_sram_rdata, 32'h22222222);

        // LED register
        drive(1'b1, A_LED, 32'hFFFFABCD);
        drive(1'b0, A_LED, 32'h0);
        check("led_out", {16'h0, led_out}, 32'h0000ABCD);
        drive(1'b0, A_IDLE, 32'h0);
        check("led_readback", bus.data_sram_rdata, 32'h0000ABCD);

        // Switch synchronizer latency and write-ignore
        drive(1'b0, A_SW, 32'h0);
        switch_in = 8'h5A;
        drive(1'b0, A_SW, 32'h0);
        check("sw_edge1", bus.data_sram_rdata, 32'h0);
        drive(1'b0, A_SW, 32'h0);
        check("sw_edge2", bus.data_sram_rdata, 32'h0);
        drive(1'b1, A_SW, 32'hFFFFFFFF);
        check("sw_edge3", bus.data_sram_rdata, 32'h0000005A);
        drive(1'b0, A_SW, 32'h0);
        drive(1'b0, A_IDLE, 32'h0);
        check("sw_ro", bus.data_sram_rdata, 32'h0000005A);

        // Scratch, TCMP and an unmapped offset
        drive(1'b1, 32'hbfaf0000, 32'hA5A55A5A);
        drive(1'b1, A_TCMP, 32'd20);
        drive(1'b0, 32'hbfaf0000, 32'h0);
        drive(1'b1, 32'hbfaf0040, 32'hFFFFFFFF);
        check("scratch_rd", bus.data_sram_rdata, 32'hA5A55A5A);
        drive(1'b0, 32'hbfaf0040, 32'h0);
        drive(1'b0, A_IDLE, 32'h0);
        check("unmapped_rd", bus.data_sram_rdata, 32'h0);

        // Timer compare interrupt
        drive(1'b1, A_TIMER, 32'h0);
        drive(1'b1, A_TCTRL, 32'h3);
        for (int k = 1; k <= 22; k++) begin
            drive(1'b0, A_TIMER, 32'h0);
            if (k == 21) check("irq_before_match", {31'h0, timer_irq}, 32'h0);
            if (k == 22) begin
                check("irq_after_match", {31'h0, timer_irq}, 32'h1);
                check("timer_at_match", bus.data_sram_rdata, 32'd20);
            end
        end
        drive(1'b1, A_TIMER, 32'd20);
        drive(1'b1, A_TCTRL, 32'h7);
        drive(1'b0, A_IDLE, 32'h0);
        check("irq_set_wins", {31'h0, timer_irq}, 32'h1);
        drive(1'b1, A_TCTRL, 32'h7);
        drive(1'b0, A_TCTRL, 32'h0);
        check("irq_cleared", {31'h0, timer_irq}, 32'h0);
        drive(1'b0, A_IDLE, 32'h0);
        check("tctrl_rd", bus.data_sram_rdata, 32'h3);

        // Timer wrap and write-over-increment
        drive(1'b1, A_TIMER, 32'hFFFFFFFE);
        drive(1'b0, A_TIMER, 32'h0);
        drive(1'b0, A_TIMER, 32'h0);
        check("timer_fffffffe", bus.data_sram_rdata, 32'hFFFFFFFE);
        drive(1'b0, A_TIMER, 32'h0);
        check("timer_ffffffff", bus.data_sram_rdata, 32'hFFFFFFFF);
        drive(1'b1, A_TIMER, 32'h100);
        check("timer_wrap", bus.data_sram_rdata, 32'h0);
        drive(1'b0, A_TIMER, 32'h0);
        drive(1'b0, A_IDLE, 32'h0);
        check("timer_wr_prio", bus.data_sram_rdata, 32'h100);

        // Asynchronous reset in the middle of a write
        drive(1'b1, 32'h1c000030, 32'hCAFEF00D);
        drive(1'b0, 32'h1c000030, 32'h0);
        drive(1'b1, 32'h1c000010, 32'hDEADBEEF);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_rdata", bus.data_sram_rdata, 32'h0);
        check("arst_led", {16'h0, led_out}, 32'h0);
        check("arst_irq", {31'h0, timer_irq}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        bus.data_sram_we = 1'b0;
        drive(1'b0, 32'h1c000010, 32'h0);
        drive(1'b0, 32'h1c000030, 32'h0);
        check("ram_kept_dropped_wr", bus.data_sram_rdata, 32'h12345678);
        drive(1'b0, A_IDLE, 32'h0);
        check("ram_kept", bus.data_sram_rdata, 32'hCAFEF00D);

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
